// File: rtl/oled_pkg.sv
// Shared constants for the SSD1331 (PmodOLEDrgb) driver: geometry, sequencer states and the
// panel init command stream.
package oled_pkg;

   localparam int unsigned WIDTH      = 96;
   localparam int unsigned HEIGHT     = 64;
   localparam int unsigned NUM_PIXELS = WIDTH * HEIGHT;
   localparam int unsigned INIT_LEN   = 19;

   typedef enum logic [2:0] {
      StPwrWait,
      StRstWait,
      StInit,
      StVccWait,
      StDispOn,
      StStream
   } oled_state_e;

   localparam logic [7:0] CmdUnlock        = 8'hFD;
   localparam logic [7:0] UnlockKey        = 8'h12;
   localparam logic [7:0] CmdDisplayOff    = 8'hAE;
   localparam logic [7:0] CmdRemap         = 8'hA0;
   localparam logic [7:0] RemapCfg         = 8'h72;
   localparam logic [7:0] CmdContrastA     = 8'h81;
   localparam logic [7:0] ContrastA        = 8'h91;
   localparam logic [7:0] CmdContrastB     = 8'h82;
   localparam logic [7:0] ContrastB        = 8'h50;
   localparam logic [7:0] CmdContrastC     = 8'h83;
   localparam logic [7:0] ContrastC        = 8'h7D;
   localparam logic [7:0] CmdMasterCurrent = 8'h87;
   localparam logic [7:0] MasterCurrent    = 8'h06;
   localparam logic [7:0] CmdPrechargeA    = 8'h8A;
   localparam logic [7:0] PrechargeA       = 8'h64;
   localparam logic [7:0] CmdPrechargeB    = 8'h8B;
   localparam logic [7:0] PrechargeB       = 8'h78;
   localparam logic [7:0] CmdPrechargeC    = 8'h8C;
   localparam logic [7:0] PrechargeC       = 8'h64;
   // Sent on its own after VCC has settled, never part of the init ROM.
   localparam logic [7:0] CmdDisplayOn     = 8'hAF;

endpackage

// File: rtl/oled_spi_driver_if.sv
// Pixel interface between the OLED driver (master, issues raster indices) and a screen
// renderer (slave, returns RGB565 data one cycle later).
interface oled_spi_driver_if;

   logic [12:0] pixel_index;
   logic [15:0] pixel_data;
   logic        frame_begin;
   logic        sample_pixel;
   logic        sending_pixels;

   modport master (
      output pixel_index,
      output frame_begin,
      output sample_pixel,
      output sending_pixels,
      input  pixel_data
   );

   modport slave (
      input  pixel_index,
      input  frame_begin,
      input  sample_pixel,
      input  sending_pixels,
      output pixel_data
   );

endinterface

// File: rtl/oled_init_rom.sv
// Combinational lookup of the SSD1331 init command bytes, sent in address order.
module oled_init_rom
   import oled_pkg::*;
(
   input  logic [4:0] addr,
   output logic [7:0] data
);

   always_comb begin
      data = 8'h00;
      case (addr)
         5'd0:    data = CmdUnlock;
         5'd1:    data = UnlockKey;
         5'd2:    data = CmdDisplayOff;
         5'd3:    data = CmdRemap;
         5'd4:    data = RemapCfg;
         5'd5:    data = CmdContrastA;
         5'd6:    data = ContrastA;
         5'd7:    data = CmdContrastB;
         5'd8:    data = ContrastB;
         5'd9:    data = CmdContrastC;
         5'd10:   data = ContrastC;
         5'd11:   data = CmdMasterCurrent;
         5'd12:   data = MasterCurrent;
         5'd13:   data = CmdPrechargeA;
         5'd14:   data = PrechargeA;
         5'd15:   data = CmdPrechargeB;
         5'd16:   data = PrechargeB;
         5'd17:   data = CmdPrechargeC;
         5'd18:   data = PrechargeC;
         default: data = 8'h00;
      endcase
   end

endmodule

// File: rtl/oled_spi_driver.sv
// SSD1331 PmodOLEDrgb driver: power-up/init sequencing, then continuous RGB565 streaming over
// SPI mode 3 (MSB first), fetching pixels from the renderer through the pixel interface.
module oled_spi_driver
   import oled_pkg::*;
#(
   parameter int unsigned CLK_DIV      = 1,
   parameter int unsigned PWR_DELAY    = 125000,
   parameter int unsigned RST_DELAY    = 20,
   parameter int unsigned VCC_DELAY    = 625000,
   parameter int unsigned FRAME_PIXELS = NUM_PIXELS
) (
   input  logic              clock,
   input  logic              reset,
   oled_spi_driver_if.master pix,
   output logic              cs,
   output logic              sclk,
   output logic              sdin,
   output logic              d_cn,
   output logic              resn,
   output logic              vccen,
   output logic              pmoden
);

   localparam logic [7:0]  DivLoad = 8'(CLK_DIV - 1);
   localparam logic [19:0] PwrLoad = 20'(PWR_DELAY - 1);
   localparam logic [19:0] RstLoad = 20'(RST_DELAY - 1);
   localparam logic [19:0] VccLoad = 20'(VCC_DELAY - 1);
   localparam logic [12:0] LastIdx = 13'(FRAME_PIXELS - 1);

   oled_state_e state_q, state_d;
   logic [19:0] dly_q, dly_d;
   logic [4:0]  addr_q, addr_d;
   logic [7:0]  rom_data;
   logic [15:0] sh_q, sh_d, hold_q, hold_d, load_word;
   logic [3:0]  bits_q, bits_d, load_bits;
   logic [7:0]  div_q, div_d;
   logic [12:0] idx_q, idx_d;
   logic [1:0]  pend_q, pend_d;
   logic        sclk_q, sclk_d, busy_q, busy_d, cs_q, cs_d, d_cn_q, d_cn_d;
   logic        resn_q, resn_d, vccen_q, vccen_d, pmoden_q, pmoden_d;
   logic        frame_begin_q, frame_begin_d, sample_q, sample_d;
   logic        prime_q, prime_d, sending_q, sending_d;
   logic        word_done, load;

   oled_init_rom u_rom (
      .addr (addr_q),
      .data (rom_data)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= StPwrWait;
         dly_q         <= PwrLoad;
         addr_q        <= '0;
         sh_q          <= '0;
         hold_q        <= '0;
         bits_q        <= '0;
         div_q         <= '0;
         idx_q         <= '0;
         pend_q        <= '0;
         sclk_q        <= 1'b1;
         busy_q        <= 1'b0;
         cs_q          <= 1'b1;
         d_cn_q        <= 1'b0;
         resn_q        <= 1'b0;
         vccen_q       <= 1'b0;
         pmoden_q      <= 1'b0;
         frame_begin_q <= 1'b0;
         sample_q      <= 1'b0;
         prime_q       <= 1'b0;
         sending_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         dly_q         <= dly_d;
         addr_q        <= addr_d;
         sh_q          <= sh_d;
         hold_q        <= hold_d;
         bits_q        <= bits_d;
         div_q         <= div_d;
         idx_q         <= idx_d;
         pend_q        <= pend_d;
         sclk_q        <= sclk_d;
         busy_q        <= busy_d;
         cs_q          <= cs_d;
         d_cn_q        <= d_cn_d;
         resn_q        <= resn_d;
         vccen_q       <= vccen_d;
         pmoden_q      <= pmoden_d;
         frame_begin_q <= frame_begin_d;
         sample_q      <= sample_d;
         prime_q       <= prime_d;
         sending_q     <= sending_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      dly_d         = dly_q;
      addr_d        = addr_q;
      sh_d          = sh_q;
      hold_d        = hold_q;
      bits_d        = bits_q;
      div_d         = div_q;
      idx_d         = idx_q;
      pend_d        = {pend_q[0], 1'b0};
      sclk_d        = sclk_q;
      busy_d        = busy_q;
      cs_d          = cs_q;
      d_cn_d        = d_cn_q;
      resn_d        = resn_q;
      vccen_d       = vccen_q;
      pmoden_d      = pmoden_q;
      frame_begin_d = 1'b0;
      sample_d      = 1'b0;
      prime_d       = prime_q;
      sending_d     = sending_q;
      word_done     = 1'b0;
      load          = 1'b0;
      load_word     = '0;
      load_bits     = '0;

      // Renderer data is valid two cycles after the index it answers.
      if (pend_q[1]) begin
         hold_d   = pix.pixel_data;
         sample_d = 1'b1;
      end

      if (busy_q) begin
         if (div_q != 8'd0) begin
            div_d = div_q - 8'd1;
         end else begin
            div_d = DivLoad;
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else if (bits_q != 4'd0) begin
               sclk_d = 1'b0;
               sh_d   = {sh_q[14:0], 1'b0};
               bits_d = bits_q - 4'd1;
            end else begin
               word_done = 1'b1;
            end
         end
      end

      unique case (state_q)
         StPwrWait: begin
            pmoden_d = 1'b1;
            if (dly_q == 20'd0) begin
               resn_d  = 1'b1;
               dly_d   = RstLoad;
               state_d = StRstWait;
            end else begin
               dly_d = dly_q - 20'd1;
            end
         end
         StRstWait: begin
            if (dly_q == 20'd0) begin
               cs_d      = 1'b0;
               d_cn_d    = 1'b0;
               load      = 1'b1;
               load_word = {rom_data, 8'h00};
               load_bits = 4'd7;
               addr_d    = addr_q + 5'd1;
               state_d   = StInit;
            end else begin
               dly_d = dly_q - 20'd1;
            end
         end
         StInit: begin
            if (word_done) begin
               if (addr_q == 5'(INIT_LEN)) begin
                  cs_d    = 1'b1;
                  busy_d  = 1'b0;
                  vccen_d = 1'b1;
                  dly_d   = VccLoad;
                  state_d = StVccWait;
               end else begin
                  load      = 1'b1;
                  load_word = {rom_data, 8'h00};
                  load_bits = 4'd7;
                  addr_d    = addr_q + 5'd1;
               end
            end
         end
         StVccWait: begin
            if (dly_q == 20'd0) begin
               cs_d      = 1'b0;
               d_cn_d    = 1'b0;
               load      = 1'b1;
               load_word = {CmdDisplayOn, 8'h00};
               load_bits = 4'd7;
               state_d   = StDispOn;
            end else begin
               dly_d = dly_q - 20'd1;
            end
         end
         StDispOn: begin
            if (word_done) begin
               cs_d          = 1'b1;
               busy_d        = 1'b0;
               d_cn_d        = 1'b1;
               sending_d     = 1'b1;
               idx_d         = '0;
               frame_begin_d = 1'b1;
               pend_d[0]     = 1'b1;
               prime_d       = 1'b1;
               state_d       = StStream;
            end
         end
         StStream: begin
            // First pixel waits for index 0 to be latched; afterwards pixels run back-to-back.
            if ((prime_q && sample_q) || word_done) begin
               prime_d   = 1'b0;
               cs_d      = 1'b0;
               load      = 1'b1;
               load_word = hold_q;
               load_bits = 4'd15;
               pend_d[0] = 1'b1;
               if (idx_q == LastIdx) begin
                  idx_d         = '0;
                  frame_begin_d = 1'b1;
               end else begin
                  idx_d = idx_q + 13'd1;
               end
            end
         end
         default: state_d = StPwrWait;
      endcase

      if (load) begin
         sh_d   = load_word;
         bits_d = load_bits;
         sclk_d = 1'b0;
         div_d  = DivLoad;
         busy_d = 1'b1;
      end
   end

   assign cs     = cs_q;
   assign sclk   = sclk_q;
   assign sdin   = sh_q[15];
   assign d_cn   = d_cn_q;
   assign resn   = resn_q;
   assign vccen  = vccen_q;
   assign pmoden = pmoden_q;

   assign pix.pixel_index    = idx_q;
   assign pix.frame_begin    = frame_begin_q;
   assign pix.sample_pixel   = sample_q;
   assign pix.sending_pixels = sending_q;

endmodule

// File: tb/tb_oled_spi_driver.sv
// Bench for oled_spi_driver: decodes the SPI stream into a queue and checks it, plus sequencing
// and pixel timing, against values the bench derives itself (short frame for run time).
module tb_oled_spi_driver;

   localparam int unsigned FramePix = 100;

   logic clock  = 1'b0;
   logic reset  = 1'b1;
   logic reset3 = 1'b1;
   logic cs, sclk, sdin, d_cn, resn, vccen, pmoden;
   logic cs3, sclk3, sdin3, d_cn3, resn3, vccen3, pmoden3;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   int unsigned cyc     = 0;

   logic [7:0]  init_tab [20] = '{8'hFD, 8'h12, 8'hAE, 8'hA0, 8'h72, 8'h81, 8'h91, 8'h82, 8'h50,
                                  8'h83, 8'h7D, 8'h87, 8'h06, 8'h8A, 8'h64, 8'h8B, 8'h78, 8'h8C,
                                  8'h64, 8'hAF};
   logic [16:0] exp_q [$];
   logic [16:0] rx_q [$];
   logic [15:0] rx_sr     = '0;
   int          rx_nb     = 0;
   logic        sclk_prev = 1'b1;

   oled_spi_driver_if pix ();
   oled_spi_driver_if pix3 ();

   oled_spi_driver #(
      .CLK_DIV      (1),
      .PWR_DELAY    (4),
      .RST_DELAY    (2),
      .VCC_DELAY    (4),
      .FRAME_PIXELS (FramePix)
   ) u_dut (
      .clock  (clock),
      .reset  (reset),
      .pix    (pix),
      .cs     (cs),
      .sclk   (sclk),
      .sdin   (sdin),
      .d_cn   (d_cn),
      .resn   (resn),
      .vccen  (vccen),
      .pmoden (pmoden)
   );

   oled_spi_driver #(
      .CLK_DIV      (3),
      .PWR_DELAY    (4),
      .RST_DELAY    (2),
      .VCC_DELAY    (4),
      .FRAME_PIXELS (FramePix)
   ) u_dut3 (
      .clock  (clock),
      .reset  (reset3),
      .pix    (pix3),
      .cs     (cs3),
      .sclk   (sclk3),
      .sdin   (sdin3),
      .d_cn   (d_cn3),
      .resn   (resn3),
      .vccen  (vccen3),
      .pmoden (pmoden3)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Renderer model: one registered cycle of latency, data = index.
   always @(posedge clock) begin
      pix.pixel_data  <= {3'b000, pix.pixel_index};
      pix3.pixel_data <= {3'b000, pix3.pixel_index};
   end

   // SPI decoder: sample sdin on sclk rising edges while cs is low; tag entries with d_cn.
   always @(negedge clock) begin
      if (reset || cs) begin
         rx_nb = 0;
      end else if (sclk && !sclk_prev) begin
         rx_sr = {rx_sr[14:0], sdin};
         rx_nb++;
         if (!d_cn && rx_nb == 8) begin
            rx_q.push_back({1'b0, 8'h00, rx_sr[7:0]});
            rx_nb = 0;
         end else if (d_cn && rx_nb == 16) begin
            rx_q.push_back({1'b1, rx_sr});
            rx_nb = 0;
         end
      end
      sclk_prev = sclk;
   end

   task automatic test_reset();
      repeat (3) @(negedge clock);
      n_tests++;
      if ({cs, sclk, sdin, d_cn, resn, vccen, pmoden} !== 7'b1100000) begin
         n_fail++;
         $display("FAIL reset_pins: got %b want %b", {cs, sclk, sdin, d_cn, resn, vccen, pmoden},
                  7'b1100000);
      end
      n_tests++;
      if (pix.pixel_index !== 13'd0) begin
         n_fail++;
         $display("FAIL reset_index: got %0d want 0", pix.pixel_index);
      end
      n_tests++;
      if ({pix.frame_begin, pix.sample_pixel, pix.sending_pixels} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b want 000",
                  {pix.frame_begin, pix.sample_pixel, pix.sending_pixels});
      end
   endtask

   // Expects reset to have just been released right after a falling clock edge.
   task automatic test_power_up();
      int n;
      @(negedge clock);
      n = 1;
      n_tests++;
      if (pmoden !== 1'b1 || resn !== 1'b0) begin
         n_fail++;
         $display("FAIL pwr_wait_pins: got pmoden=%b resn=%b want 1 0", pmoden, resn);
      end
      while (resn !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL resn_delay: got %0d cycles want 4", n);
      end
      n = 0;
      while (cs !== 1'b0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (n != 2) begin
         n_fail++;
         $display("FAIL cs_delay: got %0d cycles want 2", n);
      end
      n_tests++;
      if ({d_cn, sclk, sdin} !== 3'b001) begin
         n_fail++;
         $display("FAIL first_bit: got d_cn/sclk/sdin=%b want 001", {d_cn, sclk, sdin});
      end
   endtask

   task automatic test_init();
      int          n;
      logic [16:0] got, want;
      exp_q.delete();
      for (int i = 0; i < 20; i++) exp_q.push_back({1'b0, 8'h00, init_tab[i]});
      n = 0;
      while (cs !== 1'b1 && n < 1000) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (cs !== 1'b1 || vccen !== 1'b1) begin
         n_fail++;
         $display("FAIL vccen_on: got cs=%b vccen=%b want 1 1", cs, vccen);
      end
      n = 0;
      while (cs !== 1'b0 && n < 50) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (n != 4) begin
         n_fail++;
         $display("FAIL vcc_delay: got %0d cycles want 4", n);
      end
      n = 0;
      while (rx_q.size() < 20 && n < 500) begin
         @(negedge clock);
         n++;
      end
      for (int i = 0; i < 20; i++) begin
         want = exp_q.pop_front();
         n_tests++;
         if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL init_byte[%0d]: got nothing want %h", i, want);
         end else begin
            got = rx_q.pop_front();
            if (got !== want) begin
               n_fail++;
               $display("FAIL init_byte[%0d]: got %h want %h", i, got, want);
            end
         end
      end
   endtask

   task automatic test_stream_entry();
      int n;
      n = 0;
      while (pix.sending_pixels !== 1'b1 && n < 200) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if ({pix.sending_pixels, pix.frame_begin, d_cn} !== 3'b111 || pix.pixel_index !== 13'd0)
      begin
         n_fail++;
         $display("FAIL stream_entry: got send/fb/dcn=%b idx=%0d want 111 idx=0",
                  {pix.sending_pixels, pix.frame_begin, d_cn}, pix.pixel_index);
      end
      n = 0;
      while (pix.sample_pixel !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (n != 2) begin
         n_fail++;
         $display("FAIL entry_sample: got %0d cycles want 2", n);
      end
   endtask

   task automatic test_sample_timing();
      int          n;
      logic [12:0] prev;
      int unsigned t_chg, t_last;
      prev   = pix.pixel_index;
      t_last = 0;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (pix.pixel_index === prev && n < 200) begin
            @(negedge clock);
            n++;
         end
         t_chg = cyc;
         n_tests++;
         if (pix.pixel_index !== 13'(prev + 13'd1)) begin
            n_fail++;
            $display("FAIL idx_step: got %0d want %0d", pix.pixel_index, prev + 13'd1);
         end
         if (k > 0) begin
            n_tests++;
            if (t_chg - t_last != 32) begin
               n_fail++;
               $display("FAIL pixel_period: got %0d cycles want 32", t_chg - t_last);
            end
         end
         t_last = t_chg;
         prev   = pix.pixel_index;
         n = 0;
         while (pix.sample_pixel !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
         end
         n_tests++;
         if (n != 2) begin
            n_fail++;
            $display("FAIL sample_delay: got %0d cycles want 2", n);
         end
      end
   endtask

   task automatic test_frame_period();
      int          n;
      logic [12:0] prev;
      int unsigned t0;
      n    = 0;
      prev = pix.pixel_index;
      while (pix.frame_begin !== 1'b1 && n < 5000) begin
         prev = pix.pixel_index;
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (pix.frame_begin !== 1'b1 || prev !== 13'(FramePix - 1) || pix.pixel_index !== 13'd0)
      begin
         n_fail++;
         $display("FAIL frame_wrap: got fb=%b %0d->%0d want 1 %0d->0", pix.frame_begin, prev,
                  pix.pixel_index, FramePix - 1);
      end
      t0 = cyc;
      @(negedge clock);
      n_tests++;
      if (pix.frame_begin !== 1'b0) begin
         n_fail++;
         $display("FAIL frame_pulse_width: got fb=%b want 0", pix.frame_begin);
      end
      n = 0;
      while (pix.frame_begin !== 1'b1 && n < 5000) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (cyc - t0 != FramePix * 32) begin
         n_fail++;
         $display("FAIL frame_period: got %0d cycles want %0d", cyc - t0, FramePix * 32);
      end
   endtask

   task automatic test_pixel_words();
      int          n;
      logic [16:0] got, want;
      exp_q.delete();
      for (int k = 0; k < 200; k++) exp_q.push_back({1'b1, 16'(k % FramePix)});
      n = 0;
      while (rx_q.size() < 200 && n < 8000) begin
         @(negedge clock);
         n++;
      end
      for (int k = 0; k < 200; k++) begin
         want = exp_q.pop_front();
         n_tests++;
         if (rx_q.size() == 0) begin
            n_fail++;
            $display("FAIL pixel_word[%0d]: got nothing want %h", k, want);
         end else begin
            got = rx_q.pop_front();
            if (got !== want) begin
               n_fail++;
               $display("FAIL pixel_word[%0d]: got %h want %h", k, got, want);
            end
         end
      end
   endtask

   task automatic test_reset_mid_stream();
      int n;
      n = 0;
      while ((pix.pixel_index < 13'd5 || sclk !== 1'b0) && n < 500) begin
         @(negedge clock);
         n++;
      end
      reset = 1'b1;
      #1;
      n_tests++;
      if ({cs, sclk, vccen, resn, pix.sending_pixels} !== 5'b11000 || pix.pixel_index !== 13'd0)
      begin
         n_fail++;
         $display("FAIL reset_mid_stream: got cs/sclk/vcc/resn/send=%b idx=%0d want 11000 idx=0",
                  {cs, sclk, vccen, resn, pix.sending_pixels}, pix.pixel_index);
      end
      @(negedge clock);
      rx_q.delete();
      reset = 1'b0;
      test_power_up();
      test_init();
   endtask

   task automatic test_clk_div3();
      int          n;
      logic [12:0] prev;
      int unsigned t0;
      n = 0;
      while (pix3.sending_pixels !== 1'b1 && n < 5000) begin
         @(negedge clock);
         n++;
      end
      prev = pix3.pixel_index;
      n = 0;
      while (pix3.pixel_index === prev && n < 500) begin
         @(negedge clock);
         n++;
      end
      t0   = cyc;
      prev = pix3.pixel_index;
      n = 1;
      while (n < 20) begin
         @(negedge clock);
         if (sclk3 !== 1'b0) break;
         n++;
      end
      n_tests++;
      if (n != 3) begin
         n_fail++;
         $display("FAIL div3_low_phase: got %0d cycles want 3", n);
      end
      n = 1;
      while (n < 20) begin
         @(negedge clock);
         if (sclk3 !== 1'b1) break;
         n++;
      end
      n_tests++;
      if (n != 3) begin
         n_fail++;
         $display("FAIL div3_high_phase: got %0d cycles want 3", n);
      end
      n = 0;
      while (pix3.pixel_index === prev && n < 500) begin
         @(negedge clock);
         n++;
      end
      n_tests++;
      if (cyc - t0 != 96) begin
         n_fail++;
         $display("FAIL div3_pixel_period: got %0d cycles want 96", cyc - t0);
      end
   endtask

   initial begin
      test_reset();
      reset  = 1'b0;
      reset3 = 1'b0;
      test_power_up();
      test_init();
      test_stream_entry();
      test_sample_timing();
      test_frame_period();
      test_pixel_words();
      test_reset_mid_stream();
      test_clk_div3();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded 50000 cycles");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/oled_spi_driver.md
# oled_spi_driver

Drives the 96x64 PmodOLEDrgb (SSD1331) over 4-wire SPI and is the consumer side of the pixel interface used by every screen renderer in the design: it issues `pixel_index` in raster order and serializes the returned RGB565 `pixel_data`. It runs the panel power-up and init sequence once after reset, then streams frames continuously with no gaps.

## Interface
Parameters:
- `CLK_DIV`, 1: sclk half-period in `clock` cycles (>=1).
- `PWR_DELAY`, 125000: cycles with pmoden=1, resn=0 before reset release (20 ms at 6.25 MHz).
- `RST_DELAY`, 20: cycles after resn rises before first command.
- `VCC_DELAY`, 625000: cycles after vccen rises before display-on command.

Ports:
- `clock`  in  1  system clock (6.25 MHz); one clock, no other domains.
- `reset`  in  1  asynchronous, active-high.
- `pixel_data`  in  16  RGB565 from renderer, registered one cycle after `pixel_index`.
- `pixel_index`  out  13  raster index 0..6143 (y*96+x).
- `frame_begin`  out  1  one-cycle pulse when `pixel_index` becomes 0 in STREAM.
- `sample_pixel`  out  1  one-cycle pulse when `pixel_data` is latched.
- `sending_pixels`  out  1  high while in STREAM.
- `cs`, `sclk`, `sdin`, `d_cn`, `resn`, `vccen`, `pmoden`  out  1 each  panel pins.

## Operation
- Reset values: cs=1, sclk=1, sdin=0, d_cn=0, resn=0, vccen=0, pmoden=0, pixel_index=0, frame_begin=0, sample_pixel=0, sending_pixels=0. Reset asserted at any time (including mid-byte/mid-frame) returns to PWR_WAIT immediately.
- FSM: PWR_WAIT (pmoden=1, resn=0, PWR_DELAY cycles) -> RST_WAIT (resn=1, RST_DELAY cycles) -> INIT (cs=0, d_cn=0, send INIT_LEN ROM bytes back-to-back, then cs=1) -> VCC_WAIT (vccen=1, VCC_DELAY cycles) -> DISP_ON (cs=0, d_cn=0, send 0xAF, cs=1) -> STREAM (cs=0, d_cn=1, forever).
- SPI mode 3, MSB first: each bit = CLK_DIV cycles sclk low (sdin changes on the falling edge) then CLK_DIV cycles sclk high. Byte = 16*CLK_DIV cycles; no inter-byte gap.
- STREAM: each pixel = 16 bits (high byte first) = 32*CLK_DIV cycles. In the cycle the shift register loads pixel k, `pixel_index` advances to k+1 (6143 wraps to 0 and pulses `frame_begin`). Exactly 2 cycles later `pixel_data` is latched into the holding register with `sample_pixel`=1. On STREAM entry, index 0 is presented and latched before the first pixel is shifted; the first `frame_begin` fires on that entry.
- Delay counters are 20-bit, count down to zero; zero-length delay parameters are illegal.

## Timing
- Pixel rate: one pixel per 32*CLK_DIV cycles; frame = 6144*32*CLK_DIV cycles (196608 at CLK_DIV=1, ~31.8 fps).
- `pixel_data` is consumed 2 cycles after `pixel_index` changes; renderers must have <=1 cycle latency.
- `pixel_index` is held stable for the full pixel period.
- All outputs registered; no combinational path from `pixel_data` to pins.

## Structure
- Package `oled_pkg`: WIDTH=96, HEIGHT=64, NUM_PIXELS=6144, state enum, INIT_LEN and init byte constants (unlock 0xFD 0x12, display off 0xAE, remap 0xA0 0x72, contrast, master current, precharge; display-on 0xAF kept separate).
- Sub-module `oled_init_rom`: combinational byte lookup by 5-bit address.
- Shared byte/bit serializer logic within the top; no separate SPI module.

## Test plan
- Sim params CLK_DIV=1, PWR_DELAY=4, RST_DELAY=2, VCC_DELAY=4: release reset -> resn rises after 4 cycles, cs falls 2 cycles later, first byte on sdin is 0xFD with d_cn=0.
- Decode all INIT bytes on sclk rising edges -> match ROM exactly; cs high then vccen=1, 4 cycles later byte 0xAF.
- Renderer model returns pixel_data = {3'b0,pixel_index} -> decoded 16-bit words in STREAM are 0,1,2,...,6143,0; sample_pixel occurs 2 cycles after each index change.
- Count cycles between consecutive frame_begin pulses -> exactly 196608; pixel_index 6143 -> 0 coincident with frame_begin.
- Assert reset mid-pixel in STREAM -> same cycle cs=1, sclk=1, vccen=0, resn=0, pixel_index=0, sending_pixels=0; full sequence replays after release.
- CLK_DIV=3 -> sclk low/high phases 3 cycles each, pixel period 96 cycles.
